// File: rtl/line_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : line_window_gen
//  Purpose  : Row-buffer controller for the Harris window stage. Stores a
//             raster pixel stream row by row in WIN+1 circular row memories
//             and, once WIN complete rows are held, sweeps a WIN x WIN window
//             across them, one column step per accepted output.
//  Ports    : i_clk / i_rst_n          clock, async active-low reset
//             i_data / i_data_valid    input pixel stream
//             o_data_ready             a pixel can be accepted this cycle
//             o_window / _valid        flat window bus, element (r,c) at
//                                      [(r*WIN+c)*PIX_W +: PIX_W], r=0 oldest
//             i_window_ready           downstream accepts o_window
//             o_line_done              pulse with the last window of a band
//  Revision : 1.0  initial release
// ============================================================================
module line_window_gen #(
    parameter int IMG_WIDTH = 480,
    parameter int WIN       = 6,
    parameter int PIX_W     = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [PIX_W-1:0]           i_data,
    input  logic                       i_data_valid,
    output logic                       o_data_ready,
    output logic [WIN*WIN*PIX_W-1:0]   o_window,
    output logic                       o_window_valid,
    input  logic                       i_window_ready,
    output logic                       o_line_done
);

    localparam int NROWS = WIN + 1;
    localparam int SEL_W = $clog2(NROWS);
    localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RF_W  = $clog2(NROWS + 1);
    localparam int WBITS = WIN * WIN * PIX_W;

    localparam logic [COL_W-1:0] LAST_WR_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] LAST_RD_COL = COL_W'(IMG_WIDTH - WIN);
    localparam logic [SEL_W-1:0] LAST_SEL    = SEL_W'(NROWS - 1);
    localparam logic [RF_W-1:0]  ROWS_MAX    = RF_W'(NROWS);
    localparam logic [RF_W-1:0]  ROWS_WIN    = RF_W'(WIN);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t              state;
    logic [COL_W-1:0]    wr_col;
    logic [SEL_W-1:0]    wr_sel;
    logic [COL_W-1:0]    rd_col;
    logic [SEL_W-1:0]    rd_sel;
    logic [RF_W-1:0]     rows_full;

    logic [PIX_W-1:0]    row_mem [NROWS][IMG_WIDTH];

    logic                wr_accept;
    logic                row_done;
    logic                slot_free;
    logic                band_done;
    logic [WBITS-1:0]    window_next;
    logic [SEL_W:0]      row_idx;
    logic [COL_W-1:0]    col_idx;

    // ------------------------------------------------------------------
    // Handshake decodes
    // ------------------------------------------------------------------
    assign o_data_ready = (rows_full < ROWS_MAX);
    assign wr_accept    = i_data_valid && o_data_ready;
    assign row_done     = wr_accept && (wr_col == LAST_WR_COL);
    assign slot_free    = !o_window_valid || i_window_ready;
    // The band is released as soon as its last window is registered: the
    // window is already captured, so the oldest row may be overwritten.
    assign band_done    = (state == READ) && slot_free && (rd_col == LAST_RD_COL);

    // ------------------------------------------------------------------
    // Row memories: synchronous write, asynchronous read, no reset
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            row_mem[wr_sel][wr_col] <= i_data;
        end
    end

    // ------------------------------------------------------------------
    // Write pointers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_col <= '0;
            wr_sel <= '0;
        end else if (wr_accept) begin
            if (wr_col == LAST_WR_COL) begin
                wr_col <= '0;
                wr_sel <= (wr_sel == LAST_SEL) ? '0 : wr_sel + 1'b1;
            end else begin
                wr_col <= wr_col + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Count of complete rows held; a simultaneous row-complete and
    // band-complete cancel out.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rows_full <= '0;
        end else begin
            case ({row_done, band_done})
                2'b10:   rows_full <= rows_full + 1'b1;
                2'b01:   rows_full <= rows_full - 1'b1;
                default: rows_full <= rows_full;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Window assembly: rows rd_sel.. (mod WIN+1), columns rd_col..
    // ------------------------------------------------------------------
    always_comb begin
        window_next = '0;
        row_idx     = '0;
        col_idx     = '0;
        for (int r = 0; r < WIN; r++) begin
            row_idx = {1'b0, rd_sel} + (SEL_W + 1)'(r);
            if (row_idx >= (SEL_W + 1)'(NROWS)) begin
                row_idx = row_idx - (SEL_W + 1)'(NROWS);
            end
            for (int c = 0; c < WIN; c++) begin
                col_idx = rd_col + COL_W'(c);
                window_next[(r*WIN + c)*PIX_W +: PIX_W] = row_mem[row_idx[SEL_W-1:0]][col_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read-side FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            rd_col         <= '0;
            rd_sel         <= '0;
            o_window       <= '0;
            o_window_valid <= 1'b0;
            o_line_done    <= 1'b0;
        end else begin
            o_line_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Drain the final window of the previous band.
                    if (o_window_valid && i_window_ready) begin
                        o_window_valid <= 1'b0;
                    end
                    if (rows_full >= ROWS_WIN) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (slot_free) begin
                        o_window       <= window_next;
                        o_window_valid <= 1'b1;
                        if (band_done) begin
                            rd_col      <= '0;
                            rd_sel      <= (rd_sel == LAST_SEL) ? '0 : rd_sel + 1'b1;
                            o_line_done <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            rd_col <= rd_col + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_window_gen
//  Purpose  : Directed self-checking bench for line_window_gen with
//             IMG_WIDTH=8, WIN=3, PIX_W=8 and pixel value = row*16 + col.
//  Revision : 1.0  initial release
// ============================================================================
module tb_line_window_gen;

    localparam int IMG_WIDTH = 8;
    localparam int WIN       = 3;
    localparam int PIX_W     = 8;
    localparam int WBITS     = WIN * WIN * PIX_W;
    localparam int WPB       = IMG_WIDTH - WIN + 1;   // windows per band

    logic               i_clk;
    logic               i_rst_n;
    logic [PIX_W-1:0]   i_data;
    logic               i_data_valid;
    logic               o_data_ready;
    logic [WBITS-1:0]   o_window;
    logic               o_window_valid;
    logic               i_window_ready;
    logic               o_line_done;

    int nvec = 0;
    int nerr = 0;
    int lat_first;
    int lat_last;

    line_window_gen #(
        .IMG_WIDTH (IMG_WIDTH),
        .WIN       (WIN),
        .PIX_W     (PIX_W)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_data         (i_data),
        .i_data_valid   (i_data_valid),
        .o_data_ready   (o_data_ready),
        .o_window       (o_window),
        .o_window_valid (o_window_valid),
        .i_window_ready (i_window_ready),
        .o_line_done    (o_line_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [WBITS-1:0] exp_win(input int row0, input int col0);
        logic [WBITS-1:0] w;
        w = '0;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                w[(r*WIN + c)*PIX_W +: PIX_W] = 8'((row0 + r)*16 + col0 + c);
        return w;
    endfunction

    function automatic logic [PIX_W-1:0] pix(input int idx);
        return 8'((idx / IMG_WIDTH)*16 + (idx % IMG_WIDTH));
    endfunction

    task automatic do_reset();
        i_rst_n        = 1'b0;
        i_data         = '0;
        i_data_valid   = 1'b0;
        i_window_ready = 1'b1;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    // Streams nrows rows back to back and checks every window in order.
    // Window n belongs to band n/WPB (oldest row = band index), column n%WPB.
    // Optionally stalls the consumer for stall_len cycles at window stall_at.
    task automatic run_stream(input int nrows, input int stall_at, input int stall_len, input string tag);
        int npix;
        int total;
        int idx;
        int n;
        int cyc;
        int hold_left;
        int ld;
        bit prev_held;
        bit saw_nr;
        bit acc;
        npix      = nrows * IMG_WIDTH;
        total     = (nrows - WIN + 1) * WPB;
        idx       = 0;
        n         = 0;
        cyc       = 0;
        hold_left = stall_len;
        ld        = 0;
        prev_held = 1'b0;
        saw_nr    = 1'b0;
        lat_first = -1;
        lat_last  = -1;
        while ((n < total || idx < npix) && cyc < 400) begin
            if (o_line_done) ld++;
            if (prev_held) check({tag, "_hold_valid"}, o_window_valid, 1'b1);
            if (o_window_valid) begin
                if (lat_first < 0) lat_first = cyc;
                check({tag, "_win"}, o_window, exp_win(n / WPB, n % WPB));
                check({tag, "_line_done"}, o_line_done, (!prev_held && (n % WPB == WPB - 1)));
            end
            if (o_window_valid && n == stall_at && hold_left > 0) begin
                i_window_ready = 1'b0;
                hold_left--;
            end else begin
                i_window_ready = 1'b1;
            end
            prev_held = o_window_valid && !i_window_ready;
            if (o_window_valid && i_window_ready) n++;
            if (idx < npix) begin
                i_data       = pix(idx);
                i_data_valid = 1'b1;
            end else begin
                i_data_valid = 1'b0;
            end
            if (!o_data_ready) saw_nr = 1'b1;
            acc = i_data_valid && o_data_ready;
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx == npix) lat_last = cyc;
            end
        end
        i_data_valid   = 1'b0;
        i_window_ready = 1'b1;
        check({tag, "_pixels"}, idx, npix);
        check({tag, "_windows"}, n, total);
        check({tag, "_line_pulses"}, ld, total / WPB);
        check({tag, "_never_backpressured"}, saw_nr, 1'b0);
        check({tag, "_valid_clear"}, o_window_valid, 1'b0);
    endtask

    initial begin
        int early;
        int late;
        int guard;

        // ---------------- reset state ----------------
        do_reset();
        check("rst_valid", o_window_valid, 1'b0);
        check("rst_window", o_window, '0);
        check("rst_line_done", o_line_done, 1'b0);
        check("rst_data_ready", o_data_ready, 1'b1);

        // ---------------- test 1: single band ----------------
        run_stream(3, -1, 0, "t1");
        check("t1_latency", (lat_first > lat_last) && (lat_first - lat_last <= 3), 1'b1);

        // ---------------- test 2: consumer stall at window 1 ----------------
        do_reset();
        run_stream(3, 1, 5, "t2");

        // ---------------- test 3: back-pressure with 4 full rows ----------------
        do_reset();
        i_window_ready = 1'b0;
        early = 0;
        for (int i = 0; i < 32; i++) begin
            i_data       = pix(i);
            i_data_valid = 1'b1;
            if (!o_data_ready) early++;
            tick();
        end
        check("t3_ready_before_full", early, 0);
        check("t3_ready_low_at_33", o_data_ready, 1'b0);
        check("t3_held_valid", o_window_valid, 1'b1);
        check("t3_held_win", o_window, exp_win(0, 0));
        i_data = pix(32);
        late   = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (o_data_ready) late++;
        end
        check("t3_stays_full", late, 0);
        i_data_valid   = 1'b0;
        i_window_ready = 1'b1;
        for (int k = 0; k < WPB; k++) begin
            check("t3_band0_valid", o_window_valid, 1'b1);
            check("t3_band0_win", o_window, exp_win(0, k));
            if (k == WPB - 2) check("t3_ready_low_w4", o_data_ready, 1'b0);
            tick();
        end
        check("t3_ready_rise", o_data_ready, 1'b1);
        check("t3_valid_clear", o_window_valid, 1'b0);
        tick();
        check("t3_band1_valid", o_window_valid, 1'b1);
        check("t3_band1_win", o_window, exp_win(1, 0));

        // ---------------- test 5: async reset mid-band ----------------
        do_reset();
        for (int i = 0; i < 3 * IMG_WIDTH; i++) begin
            i_data       = pix(i);
            i_data_valid = 1'b1;
            tick();
        end
        i_data_valid = 1'b0;
        guard = 0;
        while (!o_line_done && guard < 20) begin
            tick();
            guard++;
        end
        check("t5_reach_last", o_line_done, 1'b1);
        check("t5_last_win", o_window, exp_win(0, WPB - 1));
        i_rst_n = 1'b0;
        #1;
        check("t5_async_valid", o_window_valid, 1'b0);
        check("t5_async_window", o_window, '0);
        check("t5_async_line_done", o_line_done, 1'b0);
        check("t5_async_ready", o_data_ready, 1'b1);
        #1;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        run_stream(3, -1, 0, "t5_replay");
        check("t5_latency", (lat_first > lat_last) && (lat_first - lat_last <= 3), 1'b1);

        // ---------------- test 4: 10 rows, 8 bands ----------------
        do_reset();
        run_stream(10, -1, 0, "t4");

        // ---------------- test 6: row complete and band complete coincide ----------------
        // One stall cycle at window 0 moves band-0 completion onto the edge
        // that accepts the last pixel of row 3.
        do_reset();
        run_stream(4, 0, 1, "t6");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
